// File: rtl/inst_fetch_queue.sv
// Show-ahead instruction fetch queue between IF and ID.
// Head entry is presented combinationally; data outputs read as zero (NOP) when empty.
module inst_fetch_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned GHR_WIDTH  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_en,
  input  logic [ADDR_WIDTH-1:0]    push_pc,
  input  logic [INST_WIDTH-1:0]    push_inst,
  input  logic                     push_branch_taken,
  input  logic [GHR_WIDTH-1:0]     push_pht_index,
  output logic                     full,
  input  logic                     stall_next_stage,
  output logic                     out_valid,
  output logic [ADDR_WIDTH-1:0]    pc_out,
  output logic [INST_WIDTH-1:0]    inst_out,
  output logic                     is_branch_taken_out,
  output logic [GHR_WIDTH-1:0]     pht_index_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem  [DEPTH];
  logic                  taken_mem [DEPTH];
  logic [GHR_WIDTH-1:0]  pht_mem   [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic push, pop;

  assign full      = (count_q == CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // A pop in the same cycle does not free a slot for a push while full.
  assign push = push_en & ~full;
  assign pop  = out_valid & ~stall_next_stage;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= push_pc;
      inst_mem[wr_ptr_q]  <= push_inst;
      taken_mem[wr_ptr_q] <= push_branch_taken;
      pht_mem[wr_ptr_q]   <= push_pht_index;
    end
  end

  always_comb begin
    pc_out              = '0;
    inst_out            = '0;
    is_branch_taken_out = 1'b0;
    pht_index_out       = '0;
    if (out_valid) begin
      pc_out              = pc_mem[rd_ptr_q];
      inst_out            = inst_mem[rd_ptr_q];
      is_branch_taken_out = taken_mem[rd_ptr_q];
      pht_index_out       = pht_mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table, corner sequences, and
// randomized traffic checked against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        push_en;
  logic [31:0] push_pc;
  logic [31:0] push_inst;
  logic        push_branch_taken;
  logic [4:0]  push_pht_index;
  logic        full;
  logic        stall_next_stage;
  logic        out_valid;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        is_branch_taken_out;
  logic [4:0]  pht_index_out;
  logic [3:0]  count;

  inst_fetch_queue #(
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .GHR_WIDTH (5)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .push_en            (push_en),
    .push_pc            (push_pc),
    .push_inst          (push_inst),
    .push_branch_taken  (push_branch_taken),
    .push_pht_index     (push_pht_index),
    .full               (full),
    .stall_next_stage   (stall_next_stage),
    .out_valid          (out_valid),
    .pc_out             (pc_out),
    .inst_out           (inst_out),
    .is_branch_taken_out(is_branch_taken_out),
    .pht_index_out      (pht_index_out),
    .count              (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        tk;
    logic [4:0]  pht;
  } ent_t;

  typedef struct {
    logic        r, f, p, s;
    logic [31:0] pc, inst;
    logic        tk;
    logic [4:0]  pht;
    logic        ev, ef;
    logic [3:0]  ec;
    logic [31:0] epc, einst;
    logic        etk;
    logic [4:0]  epht;
  } vec_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; the model advances from its pre-edge state.
  task automatic cyc(input logic r, input logic f, input logic p, input logic s,
                     input logic [31:0] pc, input logic [31:0] inst,
                     input logic tk, input logic [4:0] pht);
    ent_t e;
    bit   do_pop, do_push;
    rst = r; flush = f; push_en = p; stall_next_stage = s;
    push_pc = pc; push_inst = inst; push_branch_taken = tk; push_pht_index = pht;
    do_pop  = (q.size() != 0) && !s;
    do_push = p && (q.size() != DEPTH);
    e = '{pc: pc, inst: inst, tk: tk, pht: pht};
    if (r || f) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic s);
    cyc(1'b0, 1'b0, 1'b0, s, 32'h0, 32'h0, 1'b0, 5'h0);
  endtask

  task automatic push1(input logic s, input logic [31:0] pc);
    cyc(1'b0, 1'b0, 1'b1, s, pc, ~pc, pc[2], pc[6:2]);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 5'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 5'h0);
  endtask

  task automatic chk_model(input string tag);
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk({tag, ".valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, ".full"},  64'(full),      64'(q.size() == DEPTH));
    chk({tag, ".count"}, 64'(count),     64'(q.size()));
    chk({tag, ".pc"},    64'(pc_out),    64'(h.pc));
    chk({tag, ".inst"},  64'(inst_out),  64'(h.inst));
    chk({tag, ".tk"},    64'(is_branch_taken_out), 64'(h.tk));
    chk({tag, ".pht"},   64'(pht_index_out), 64'(h.pht));
  endtask

  function automatic vec_t mk(logic r, logic f, logic p, logic s,
                              logic [31:0] pc, logic [31:0] inst, logic tk, logic [4:0] pht,
                              logic ev, logic ef, logic [3:0] ec, logic [31:0] epc,
                              logic [31:0] einst, logic etk, logic [4:0] epht);
    vec_t v;
    v.r = r; v.f = f; v.p = p; v.s = s; v.pc = pc; v.inst = inst; v.tk = tk; v.pht = pht;
    v.ev = ev; v.ef = ef; v.ec = ec; v.epc = epc; v.einst = einst; v.etk = etk; v.epht = epht;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    rst = 1'b1; flush = 1'b0; push_en = 1'b0; stall_next_stage = 1'b1;
    push_pc = '0; push_inst = '0; push_branch_taken = 1'b0; push_pht_index = '0;

    // Expected values are the outputs after the edge of each row.
    vecs[0] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 5'h0,
                 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 5'h0);
    vecs[1] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 5'h0,
                 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 5'h0);
    vecs[2] = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'hbfc00000, 32'h90001234, 1'b0, 5'h3,
                 1'b1, 1'b0, 4'd1, 32'hbfc00000, 32'h90001234, 1'b0, 5'h3);
    vecs[3] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 5'h0,
                 1'b1, 1'b0, 4'd1, 32'hbfc00000, 32'h90001234, 1'b0, 5'h3);
    vecs[4] = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'hbfc00004, 32'h11111111, 1'b1, 5'h0a,
                 1'b1, 1'b0, 4'd2, 32'hbfc00000, 32'h90001234, 1'b0, 5'h3);
    vecs[5] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0,
                 1'b1, 1'b0, 4'd1, 32'hbfc00004, 32'h11111111, 1'b1, 5'h0a);
    vecs[6] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc00008, 32'h22222222, 1'b0, 5'h1f,
                 1'b1, 1'b0, 4'd1, 32'hbfc00008, 32'h22222222, 1'b0, 5'h1f);
    vecs[7] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'hdeadbeef, 32'hdeadbeef, 1'b1, 5'h1,
                 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 5'h0);
    vecs[8] = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'hbfc0000c, 32'h33333333, 1'b1, 5'h15,
                 1'b1, 1'b0, 4'd1, 32'hbfc0000c, 32'h33333333, 1'b1, 5'h15);
    vecs[9] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0,
                 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 5'h0);

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].r, vecs[i].f, vecs[i].p, vecs[i].s,
          vecs[i].pc, vecs[i].inst, vecs[i].tk, vecs[i].pht);
      chk($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d.full", i),  64'(full),      64'(vecs[i].ef));
      chk($sformatf("vec%0d.count", i), 64'(count),     64'(vecs[i].ec));
      chk($sformatf("vec%0d.pc", i),    64'(pc_out),    64'(vecs[i].epc));
      chk($sformatf("vec%0d.inst", i),  64'(inst_out),  64'(vecs[i].einst));
      chk($sformatf("vec%0d.tk", i),    64'(is_branch_taken_out), 64'(vecs[i].etk));
      chk($sformatf("vec%0d.pht", i),   64'(pht_index_out), 64'(vecs[i].epht));
    end

    // Fill to full, ninth push ignored, then drain in order.
    do_reset();
    for (int i = 0; i < 8; i++) push1(1'b1, 32'hbfc00000 + 32'(4 * i));
    chk("fill.full", 64'(full), 64'd1);
    chk("fill.count", 64'(count), 64'd8);
    push1(1'b1, 32'hbfc00020);
    chk("ninth.count", 64'(count), 64'd8);
    chk_model("ninth");
    // Push offered while full and popping must still be dropped.
    push1(1'b0, 32'hbfc00020);
    chk("fullpop.count", 64'(count), 64'd7);
    chk("fullpop.pc", 64'(pc_out), 64'h0bfc00004);
    do_reset();
    for (int i = 0; i < 8; i++) push1(1'b1, 32'hbfc00000 + 32'(4 * i));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d.pc", i), 64'(pc_out), 64'(32'hbfc00000 + 32'(4 * i)));
      idle(1'b0);
    end
    chk("drain.valid", 64'(out_valid), 64'd0);
    chk("drain.pc", 64'(pc_out), 64'd0);

    // Steady push+pop at count 4; pointers wrap.
    do_reset();
    for (int i = 0; i < 4; i++) push1(1'b1, 32'h1000 + 32'(4 * i));
    for (int k = 0; k < 20; k++) begin
      push1(1'b0, 32'h1010 + 32'(4 * k));
      chk($sformatf("steady%0d.count", k), 64'(count), 64'd4);
      chk($sformatf("steady%0d.pc", k), 64'(pc_out), 64'(32'h1004 + 32'(4 * k)));
    end
    chk_model("steady");

    // Flush with concurrent push.
    do_reset();
    for (int i = 0; i < 5; i++) push1(1'b1, 32'h2000 + 32'(4 * i));
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h2100, 32'h2100, 1'b1, 5'h7);
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.valid", 64'(out_valid), 64'd0);
    push1(1'b1, 32'h3000);
    chk("postflush.count", 64'(count), 64'd1);
    chk("postflush.pc", 64'(pc_out), 64'h3000);
    idle(1'b0);
    chk("postflush.empty", 64'(out_valid), 64'd0);

    // Prediction fields travel with the entry.
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h4000 + 32'(4 * i), 32'h0, 1'b0, 5'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h400c, 32'h5555aaaa, 1'b1, 5'h15);
    for (int i = 0; i < 3; i++) idle(1'b0);
    chk("pred.tk", 64'(is_branch_taken_out), 64'd1);
    chk("pred.pht", 64'(pht_index_out), 64'h15);
    chk("pred.pc", 64'(pc_out), 64'h400c);

    // Randomized traffic against the reference queue.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic r, f, p, s;
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 39) == 0);
      p = ($urandom_range(0, 9) < 6);
      s = ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 3 : 7));
      cyc(r, f, p, s, $urandom(), $urandom(), 1'($urandom()), 5'($urandom()));
      chk_model($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
